rng_sched: RTL and testbench
============================

RNG_SCHED -- requirements
Module: rng_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the generator, range 2..8.
REQ-002 Parameter WARMUP, default 64: LFSR steps after seed load before first grant, range 0..255.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port seed  input  64: seed value, sampled when seed_load is high.
REQ-006 Port seed_load  input  1: single-cycle pulse requesting reseed.
REQ-007 Port req  input  NREQ: per-requester request for one 64-bit random word, held until granted.
REQ-008 Port gnt  output  NREQ: one-hot, one-cycle grant pulse.
REQ-009 Port rnd_valid  output  1: high in exactly the cycles gnt is nonzero.
REQ-010 Port rnd_data  output  64: random word delivered with gnt, valid only while rnd_valid is high.
REQ-011 Port busy  output  1: high whenever the FSM is not in READY.
REQ-012 Port gnt_count  output  32: total grants issued (see Configuration).

Function
REQ-013 The block contains one 64-bit LFSR register; each step is lfsr <= {lfsr[62:0], ~(lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59])}.
REQ-014 Seed load writes seed into the LFSR, except seed = 64'hFFFF_FFFF_FFFF_FFFF (XNOR lock-up), which loads 64'hFFFF_FFFF_FFFF_FFFE.
REQ-015 FSM states: IDLE (unseeded), LOAD, WARM, READY.
REQ-016 IDLE -> LOAD on seed_load; no grants in IDLE, and req is ignored.
REQ-017 LOAD lasts one cycle, loads the LFSR, clears the warm-up counter, then goes to WARM, or to READY when WARMUP = 0.
REQ-018 WARM steps the LFSR every cycle and enters READY on the cycle after WARMUP steps are complete.
REQ-019 seed_load in any state forces LOAD next cycle: it aborts any warm-up, discards pending arbitration and issues no grant that cycle.
REQ-020 READY: requests sampled in cycle N produce registered gnt, rnd_valid and rnd_data in cycle N+1; at most one grant per cycle.
REQ-021 rnd_data equals the LFSR value before the step; the LFSR steps exactly once per grant and holds when no grant is issued.
REQ-022 Round-robin priority: after granting requester i, the search starts at (i+1) mod NREQ; the pointer resets to 0.
REQ-023 A requester whose gnt is high in cycle N has its req ignored in cycle N, so a held req cannot double-grant.
REQ-024 A single active requester is granted every second cycle; with all requesters active, grants rotate 0,1,...,NREQ-1,0.

Reset
REQ-025 On reset assertion, regardless of clk: FSM = IDLE, LFSR = 0, warm-up counter = 0, pointer = 0, gnt = 0, rnd_valid = 0, rnd_data = 0, busy = 1, gnt_count = 0.
REQ-026 Reset mid-warm-up or mid-grant discards all progress; reseeding is required after reset deassertion.

Configuration
REQ-027 Macro RNG_SCHED_STATS_EN defined: gnt_count increments by 1 per grant, wraps at 2^32, and clears on reset and on seed load.
REQ-028 Macro RNG_SCHED_STATS_EN undefined: the gnt_count port remains, is tied to 0, and no counter logic is synthesised.

Verification
REQ-029 Reset, seed=64'h1, seed_load, WARMUP=4, req=4'b0001 held -> busy falls after LOAD plus 4 WARM cycles; first rnd_data=64'h1F, second 64'h3F, with gnt=0001 every other cycle.
REQ-030 READY, req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rnd_data values are successive LFSR steps with no repeats; gnt_count=8 (STATS_EN).
REQ-031 seed=64'hFFFF_FFFF_FFFF_FFFF, WARMUP=0 -> first rnd_data=64'hFFFF_FFFF_FFFF_FFFE and the next word differs from it.
REQ-032 seed_load on warm-up cycle 2 with a new seed -> warm-up restarts from the new seed, busy stays high, no gnt until the full WARMUP completes.
REQ-033 reset asserted between clock edges during READY with req pending -> gnt, rnd_valid and busy take reset values immediately; no grants after deassertion until seed_load.
REQ-034 No seed_load after reset, req=4'b1111 held for 100 cycles -> gnt stays 0 and busy stays 1.

Source files
------------

// File: rtl/rng_sched.sv
// Round-robin scheduler that hands out 64-bit words from a seeded, warmed-up XNOR LFSR.
// Optional grant statistics counter is enabled by defining RNG_SCHED_STATS_EN.
module rng_sched #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [63:0]     seed,
    input  logic            seed_load,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [63:0]     rnd_data,
    output logic            busy,
    output logic [31:0]     gnt_count
);
    localparam int PW = $clog2(NREQ);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARM, S_READY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [63:0]     r_lfsr;
    logic [63:0]     r_seed;
    logic [7:0]      r_warm;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_rnd_valid;
    logic [63:0]     r_rnd_data;

    logic [NREQ-1:0] w_req_eff;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic            w_grant;
    int              w_j;

    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
    endfunction

    // All-ones is the XNOR lock-up state; nudge it to a legal value.
    function automatic logic [63:0] seed_fix(input logic [63:0] s);
        return (s == 64'hFFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFE : s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (seed_load) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_LOAD:  w_state_nxt = (WARMUP == 0) ? S_READY : S_WARM;
                S_WARM:  if (r_warm == WARM_LAST) w_state_nxt = S_READY;
                S_READY: w_state_nxt = S_READY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A requester granted this cycle is masked so a held req cannot win twice in a row.
    always_comb begin
        w_req_eff = req & ~r_gnt;
        w_gnt_nxt = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && w_req_eff[w_j]) begin
                w_found = 1'b1;
                w_idx   = PW'(w_j);
            end
        end
        if (w_found) w_gnt_nxt[w_idx] = 1'b1;
    end

    assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
    assign w_grant   = (r_state == S_READY) && !seed_load && w_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr      <= '0;
            r_seed      <= '0;
            r_warm      <= '0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= '0;
        end else begin
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
            if (seed_load) begin
                r_seed <= seed_fix(seed);
                r_ptr  <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_lfsr <= r_seed;
                        r_warm <= '0;
                    end
                    S_WARM: begin
                        r_lfsr <= lfsr_step(r_lfsr);
                        r_warm <= r_warm + 8'd1;
                    end
                    S_READY: begin
                        if (w_grant) begin
                            r_gnt       <= w_gnt_nxt;
                            r_rnd_valid <= 1'b1;
                            r_rnd_data  <= r_lfsr;
                            r_lfsr      <= lfsr_step(r_lfsr);
                            r_ptr       <= w_ptr_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RNG_SCHED_STATS_EN
    logic [31:0] r_gnt_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_gnt_count <= '0;
        else if (seed_load) r_gnt_count <= '0;
        else if (w_grant)   r_gnt_count <= r_gnt_count + 32'd1;
    end

    assign gnt_count = r_gnt_count;
`else
    assign gnt_count = 32'd0;
`endif

    assign gnt       = r_gnt;
    assign rnd_valid = r_rnd_valid;
    assign rnd_data  = r_rnd_data;
    assign busy      = (r_state != S_READY);

endmodule

// File: tb/tb_rng_sched.sv
// Directed bench for rng_sched: one instance with WARMUP=4, one with WARMUP=0.
module tb_rng_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] seed_a, seed_b;
    logic        ld_a, ld_b;
    logic [3:0]  req_a, req_b;
    logic [3:0]  gnt_a, gnt_b;
    logic        vld_a, vld_b;
    logic [63:0] data_a, data_b;
    logic        busy_a, busy_b;
    logic [31:0] cnt_a, cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef RNG_SCHED_STATS_EN
    localparam logic [31:0] EXP_CNT8 = 32'd8;
`else
    localparam logic [31:0] EXP_CNT8 = 32'd0;
`endif

    always #5 clk = ~clk;

    rng_sched #(.NREQ(4), .WARMUP(4)) u_w4 (
        .clk(clk), .reset(reset), .seed(seed_a), .seed_load(ld_a), .req(req_a),
        .gnt(gnt_a), .rnd_valid(vld_a), .rnd_data(data_a), .busy(busy_a), .gnt_count(cnt_a)
    );

    rng_sched #(.NREQ(4), .WARMUP(0)) u_w0 (
        .clk(clk), .reset(reset), .seed(seed_b), .seed_load(ld_b), .req(req_b),
        .gnt(gnt_b), .rnd_valid(vld_b), .rnd_data(data_b), .busy(busy_b), .gnt_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        seed_a = '0; seed_b = '0; ld_a = 1'b0; ld_b = 1'b0; req_a = '0; req_b = '0;
        tick();
        tick();
        n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld_a); end
        n_cmp++; if (data_a !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy_a); end
        n_cmp++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
        n_cmp++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL reset_busy_b: got %b want 1", busy_b); end
        reset = 1'b0;
    endtask

    task automatic test_no_seed();
        req_a = 4'b1111;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL noseed_gnt[%0d]: got %b want 0000", i, gnt_a); end
            n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL noseed_busy[%0d]: got %b want 1", i, busy_a); end
        end
        req_a = '0;
    endtask

    task automatic test_warmup();
        seed_a = 64'h1; ld_a = 1'b1;
        tick();
        ld_a = 1'b0; req_a = 4'b0001;
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL warm_busy_load: got %b want 1", busy_a); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL warm_busy[%0d]: got %b want 1", i, busy_a); end
            n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL warm_gnt[%0d]: got %b want 0000", i, gnt_a); end
        end
        tick();
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL warm_ready_busy: got %b want 0", busy_a); end
        n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL warm_ready_gnt: got %b want 0000", gnt_a); end
        tick();
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL warm_gnt1: got %b want 0001", gnt_a); end
        n_cmp++; if (vld_a !== 1'b1) begin n_fail++; $display("FAIL warm_vld1: got %b want 1", vld_a); end
        n_cmp++; if (data_a !== 64'h1F) begin n_fail++; $display("FAIL warm_data1: got %h want 1f", data_a); end
        tick();
        n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL warm_gap_gnt: got %b want 0000", gnt_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL warm_gap_vld: got %b want 0", vld_a); end
        tick();
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL warm_gnt2: got %b want 0001", gnt_a); end
        n_cmp++; if (data_a !== 64'h3F) begin n_fail++; $display("FAIL warm_data2: got %h want 3f", data_a); end
        req_a = '0;
        tick();
        n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL warm_idle_gnt: got %b want 0000", gnt_a); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [63:0] exp_d [8] = '{64'h1F, 64'h3F, 64'h7F, 64'hFF, 64'h1FF, 64'h3FF, 64'h7FF, 64'hFFF};
        seed_a = 64'h1; ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        repeat (5) tick();
        req_a = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (gnt_a !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_a, exp_g[i]); end
            n_cmp++; if (data_a !== exp_d[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, data_a, exp_d[i]); end
        end
        req_a = '0;
        n_cmp++; if (cnt_a !== EXP_CNT8) begin n_fail++; $display("FAIL rr_count: got %0d want %0d", cnt_a, EXP_CNT8); end
        tick();
    endtask

    task automatic test_lockup_seed();
        seed_b = 64'hFFFF_FFFF_FFFF_FFFF; ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        tick();
        n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL lock_busy: got %b want 0", busy_b); end
        req_b = 4'b0001;
        tick();
        n_cmp++; if (gnt_b !== 4'b0001) begin n_fail++; $display("FAIL lock_gnt1: got %b want 0001", gnt_b); end
        n_cmp++; if (data_b !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL lock_data1: got %h want fffffffffffffffe", data_b); end
        tick();
        tick();
        n_cmp++; if (gnt_b !== 4'b0001) begin n_fail++; $display("FAIL lock_gnt2: got %b want 0001", gnt_b); end
        n_cmp++; if (data_b !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL lock_data2: got %h want fffffffffffffffd", data_b); end
        req_b = '0;
    endtask

    task automatic test_reseed_abort();
        seed_a = 64'h1; ld_a = 1'b1; req_a = 4'b0001;
        tick();
        ld_a = 1'b0;
        tick();
        tick();
        seed_a = 64'h100; ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_busy[%0d]: got %b want 1", i, busy_a); end
            n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL abort_gnt[%0d]: got %b want 0000", i, gnt_a); end
            tick();
        end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready_busy: got %b want 0", busy_a); end
        tick();
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL abort_gnt: got %b want 0001", gnt_a); end
        n_cmp++; if (data_a !== 64'h100F) begin n_fail++; $display("FAIL abort_data: got %h want 100f", data_a); end
        req_a = '0;
        tick();
    endtask

    task automatic test_async_reset();
        seed_a = 64'h1; ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        repeat (5) tick();
        req_a = 4'b1111;
        tick();
        n_cmp++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL areset_pre_gnt: got %b want 0001", gnt_a); end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL areset_gnt: got %b want 0000", gnt_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL areset_vld: got %b want 0", vld_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL areset_busy: got %b want 1", busy_a); end
        n_cmp++; if (data_a !== 64'h0) begin n_fail++; $display("FAIL areset_data: got %h want 0", data_a); end
        n_cmp++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", cnt_a); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (gnt_a !== 4'b0) begin n_fail++; $display("FAIL post_reset_gnt[%0d]: got %b want 0000", i, gnt_a); end
            n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL post_reset_busy[%0d]: got %b want 1", i, busy_a); end
        end
        req_a = '0;
    endtask

    initial begin
        test_reset();
        test_no_seed();
        test_warmup();
        test_round_robin();
        test_lockup_seed();
        test_reseed_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
